// File: rtl/wb_conmax_2m4s.sv
// ---------------------------------------------------------------------------
// wb_conmax_2m4s
//   Wishbone interconnect placed directly behind the CPU core's two masters
//   (m0 = data bus, m1 = instruction bus). Round-robin arbitration between
//   the masters and an address decode on addr[31:28] onto four slaves
//   (ROM, RAM, GPIO, UART). Unmapped accesses get a one-cycle error
//   completion, and a per-transaction ack timeout forces an error completion
//   so a missing slave can never stall the pipeline.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m{0,1}_addr_i/data_i     master address / write data
//   m{0,1}_we_i/sel_i        master write enable / byte selects
//   m{0,1}_stb_i/cyc_i       master strobe / cycle request
//   m{0,1}_data_o/ack_o      read data / ack back to the master
//   s{0..3}_*_o              address, write data, we, sel, stb, cyc to slave
//   s{0..3}_data_i/ack_i     slave read data / ack
//   bus_err_o                one-cycle pulse on unmapped access or timeout
// ---------------------------------------------------------------------------
module wb_conmax_2m4s #(
   parameter logic [3:0] S0_TAG  = 4'h0,
   parameter logic [3:0] S1_TAG  = 4'h1,
   parameter logic [3:0] S2_TAG  = 4'h2,
   parameter logic [3:0] S3_TAG  = 4'h3,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,

   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,

   output logic [31:0] s0_addr_o,
   output logic [31:0] s0_data_o,
   output logic        s0_we_o,
   output logic [3:0]  s0_sel_o,
   output logic        s0_stb_o,
   output logic        s0_cyc_o,
   input  logic [31:0] s0_data_i,
   input  logic        s0_ack_i,

   output logic [31:0] s1_addr_o,
   output logic [31:0] s1_data_o,
   output logic        s1_we_o,
   output logic [3:0]  s1_sel_o,
   output logic        s1_stb_o,
   output logic        s1_cyc_o,
   input  logic [31:0] s1_data_i,
   input  logic        s1_ack_i,

   output logic [31:0] s2_addr_o,
   output logic [31:0] s2_data_o,
   output logic        s2_we_o,
   output logic [3:0]  s2_sel_o,
   output logic        s2_stb_o,
   output logic        s2_cyc_o,
   input  logic [31:0] s2_data_i,
   input  logic        s2_ack_i,

   output logic [31:0] s3_addr_o,
   output logic [31:0] s3_data_o,
   output logic        s3_we_o,
   output logic [3:0]  s3_sel_o,
   output logic        s3_stb_o,
   output logic        s3_cyc_o,
   input  logic [31:0] s3_data_i,
   input  logic        s3_ack_i,

   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last_grant;
   logic        w_last_grant_nxt;
   logic [7:0]  r_tmo_cnt;

   logic        w_granted;
   logic        w_own_m1;
   logic [31:0] w_addr;
   logic [31:0] w_wdat;
   logic        w_we;
   logic [3:0]  w_sel;
   logic        w_stb;
   logic        w_cyc;
   logic [3:0]  w_hit;
   logic        w_mapped;
   logic [1:0]  w_idx;
   logic        w_timeout;
   logic        w_route;
   logic [3:0]  w_s_en;
   logic [3:0]  w_s_ack;
   logic [31:0] w_s_dat [4];
   logic        w_slv_ack;
   logic [31:0] w_slv_dat;
   logic        w_err;
   logic        w_mst_ack;

   // last_grant is written together with every grant, so in GNTx and ERR it
   // always names the master that owns the bus.
   assign w_granted = (r_state == GNT0) || (r_state == GNT1);
   assign w_own_m1  = r_last_grant;

   assign w_addr = w_own_m1 ? m1_addr_i : m0_addr_i;
   assign w_wdat = w_own_m1 ? m1_data_i : m0_data_i;
   assign w_we   = w_own_m1 ? m1_we_i   : m0_we_i;
   assign w_sel  = w_own_m1 ? m1_sel_i  : m0_sel_i;
   assign w_stb  = w_own_m1 ? m1_stb_i  : m0_stb_i;
   assign w_cyc  = w_own_m1 ? m1_cyc_i  : m0_cyc_i;

   assign w_hit = {w_addr[31:28] == S3_TAG, w_addr[31:28] == S2_TAG,
                   w_addr[31:28] == S1_TAG, w_addr[31:28] == S0_TAG};
   assign w_mapped = |w_hit;

   // Lowest slave index wins if two tags are configured identically.
   always_comb begin
      w_idx = 2'd0;
      for (int unsigned i = 4; i > 0; i--) begin
         if (w_hit[i-1]) w_idx = 2'(i - 1);
      end
   end

   always_comb begin
      w_s_ack    = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
      w_s_dat[0] = s0_data_i;
      w_s_dat[1] = s1_data_i;
      w_s_dat[2] = s2_data_i;
      w_s_dat[3] = s3_data_i;
   end

   // Timeout completion takes the slave off the bus in the same cycle, so a
   // coincident slave ack is never passed through.
   assign w_timeout = w_granted && w_stb && (r_tmo_cnt == TIMEOUT);
   assign w_route   = w_granted && w_mapped && !w_timeout;
   assign w_s_en    = w_route ? (4'b0001 << w_idx) : '0;
   assign w_slv_ack = w_route && w_s_ack[w_idx];
   assign w_slv_dat = w_slv_ack ? w_s_dat[w_idx] : '0;
   assign w_err     = (r_state == ERR) || w_timeout;
   assign w_mst_ack = w_slv_ack || w_err;

   assign m0_ack_o  = w_mst_ack && !w_own_m1;
   assign m1_ack_o  = w_mst_ack &&  w_own_m1;
   assign m0_data_o = w_own_m1 ? '0 : w_slv_dat;
   assign m1_data_o = w_own_m1 ? w_slv_dat : '0;
   assign bus_err_o = w_err;

   assign s0_addr_o = w_s_en[0] ? w_addr : '0;
   assign s0_data_o = w_s_en[0] ? w_wdat : '0;
   assign s0_we_o   = w_s_en[0] && w_we;
   assign s0_sel_o  = w_s_en[0] ? w_sel  : '0;
   assign s0_stb_o  = w_s_en[0] && w_stb;
   assign s0_cyc_o  = w_s_en[0] && w_cyc;

   assign s1_addr_o = w_s_en[1] ? w_addr : '0;
   assign s1_data_o = w_s_en[1] ? w_wdat : '0;
   assign s1_we_o   = w_s_en[1] && w_we;
   assign s1_sel_o  = w_s_en[1] ? w_sel  : '0;
   assign s1_stb_o  = w_s_en[1] && w_stb;
   assign s1_cyc_o  = w_s_en[1] && w_cyc;

   assign s2_addr_o = w_s_en[2] ? w_addr : '0;
   assign s2_data_o = w_s_en[2] ? w_wdat : '0;
   assign s2_we_o   = w_s_en[2] && w_we;
   assign s2_sel_o  = w_s_en[2] ? w_sel  : '0;
   assign s2_stb_o  = w_s_en[2] && w_stb;
   assign s2_cyc_o  = w_s_en[2] && w_cyc;

   assign s3_addr_o = w_s_en[3] ? w_addr : '0;
   assign s3_data_o = w_s_en[3] ? w_wdat : '0;
   assign s3_we_o   = w_s_en[3] && w_we;
   assign s3_sel_o  = w_s_en[3] ? w_sel  : '0;
   assign s3_stb_o  = w_s_en[3] && w_stb;
   assign s3_cyc_o  = w_s_en[3] && w_cyc;

   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               w_last_grant_nxt = !r_last_grant;
               w_state_nxt      = r_last_grant ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               w_last_grant_nxt = 1'b0;
               w_state_nxt      = GNT0;
            end else if (m1_cyc_i) begin
               w_last_grant_nxt = 1'b1;
               w_state_nxt      = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (!w_cyc) begin
               w_state_nxt = IDLE;
            end else if (w_stb && !w_mapped) begin
               w_state_nxt = ERR;
            end
         end
         ERR:     w_state_nxt = r_last_grant ? GNT1 : GNT0;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_tmo_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         if (!w_granted || !w_stb || !w_mapped || w_mst_ack) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_conmax_2m4s.sv
// ---------------------------------------------------------------------------
// tb_wb_conmax_2m4s
//   Directed-plus-random bench for wb_conmax_2m4s. Master and slave sides are
//   driven from one initial block; expectations come from the address map
//   (addr[31:28] = slave index for 0..3) and a round-robin owner model.
// ---------------------------------------------------------------------------
module tb_wb_conmax_2m4s;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] m_addr [2];
   logic [31:0] m_wdat [2];
   logic        m_we   [2];
   logic [3:0]  m_sel  [2];
   logic        m_stb  [2];
   logic        m_cyc  [2];
   logic [31:0] m_dat  [2];
   logic        m_ack  [2];

   logic [31:0] s_addr [4];
   logic [31:0] s_wdat [4];
   logic        s_we   [4];
   logic [3:0]  s_sel  [4];
   logic        s_stb  [4];
   logic        s_cyc  [4];
   logic [31:0] s_rdat [4];
   logic        s_ack  [4];

   logic        bus_err;

   int n_cmp = 0;
   int n_mis = 0;
   int model_last;

   always #5 clk = ~clk;

   wb_conmax_2m4s dut (
      .clk       (clk),
      .rst       (rst),
      .m0_addr_i (m_addr[0]), .m0_data_i (m_wdat[0]), .m0_we_i (m_we[0]),
      .m0_sel_i  (m_sel[0]),  .m0_stb_i  (m_stb[0]),  .m0_cyc_i (m_cyc[0]),
      .m0_data_o (m_dat[0]),  .m0_ack_o  (m_ack[0]),
      .m1_addr_i (m_addr[1]), .m1_data_i (m_wdat[1]), .m1_we_i (m_we[1]),
      .m1_sel_i  (m_sel[1]),  .m1_stb_i  (m_stb[1]),  .m1_cyc_i (m_cyc[1]),
      .m1_data_o (m_dat[1]),  .m1_ack_o  (m_ack[1]),
      .s0_addr_o (s_addr[0]), .s0_data_o (s_wdat[0]), .s0_we_o (s_we[0]),
      .s0_sel_o  (s_sel[0]),  .s0_stb_o  (s_stb[0]),  .s0_cyc_o (s_cyc[0]),
      .s0_data_i (s_rdat[0]), .s0_ack_i  (s_ack[0]),
      .s1_addr_o (s_addr[1]), .s1_data_o (s_wdat[1]), .s1_we_o (s_we[1]),
      .s1_sel_o  (s_sel[1]),  .s1_stb_o  (s_stb[1]),  .s1_cyc_o (s_cyc[1]),
      .s1_data_i (s_rdat[1]), .s1_ack_i  (s_ack[1]),
      .s2_addr_o (s_addr[2]), .s2_data_o (s_wdat[2]), .s2_we_o (s_we[2]),
      .s2_sel_o  (s_sel[2]),  .s2_stb_o  (s_stb[2]),  .s2_cyc_o (s_cyc[2]),
      .s2_data_i (s_rdat[2]), .s2_ack_i  (s_ack[2]),
      .s3_addr_o (s_addr[3]), .s3_data_o (s_wdat[3]), .s3_we_o (s_we[3]),
      .s3_sel_o  (s_sel[3]),  .s3_stb_o  (s_stb[3]),  .s3_cyc_o (s_cyc[3]),
      .s3_data_i (s_rdat[3]), .s3_ack_i  (s_ack[3]),
      .bus_err_o (bus_err)
   );

   // Slave index from the default address map, -1 when unmapped.
   function automatic int dec(input logic [31:0] a);
      int t;
      t = int'(a[31:28]);
      return (t < 4) ? t : -1;
   endfunction

   function automatic logic [31:0] rnd_addr(input int t);
      logic [27:0] off;
      off = 28'($urandom);
      return {4'(t), off[27:2], 2'b00};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every slave must be idle except the one decoded from master m's address,
   // which must carry master m's request fields. m = -1: nothing routed.
   task automatic chk_route(input string tag, input int m);
      logic [70:0] obs;
      logic [70:0] exp;
      int          k;
      k = (m >= 0) ? dec(m_addr[m]) : -1;
      for (int j = 0; j < 4; j++) begin
         obs = {s_cyc[j], s_stb[j], s_we[j], s_sel[j], s_addr[j], s_wdat[j]};
         exp = '0;
         if (j == k) exp = {m_cyc[m], m_stb[m], m_we[m], m_sel[m], m_addr[m], m_wdat[m]};
         chk($sformatf("%s_s%0d", tag, j), 128'(obs), 128'(exp));
      end
   endtask

   task automatic chk_mst(input string tag, input int m, input logic ack, input logic [31:0] dat);
      chk($sformatf("%s_m%0d_ack", tag, m), 128'(m_ack[m]), 128'(ack));
      chk($sformatf("%s_m%0d_dat", tag, m), 128'(m_dat[m]), 128'(dat));
   endtask

   task automatic chk_err(input string tag, input logic e);
      chk({tag, "_buserr"}, 128'(bus_err), 128'(e));
   endtask

   task automatic req(input int m, input logic [31:0] a);
      m_addr[m] = a;
      m_wdat[m] = $urandom;
      m_we[m]   = 1'($urandom_range(0, 1));
      m_sel[m]  = 4'($urandom_range(1, 15));
      m_cyc[m]  = 1'b1;
      m_stb[m]  = 1'b1;
   endtask

   // One transfer by master m, which already owns the bus this cycle; the
   // slave acks after lat wait cycles. Ends one cycle after the ack with stb low.
   task automatic xfer(input int m, input logic [31:0] a, input int lat,
                       input logic [31:0] rd, input string tag);
      int k;
      k = dec(a);
      req(m, a);
      for (int i = 0; i < lat; i++) begin
         s_rdat[k] = $urandom;
         #1;
         chk_route({tag, "_wait"}, m);
         chk_mst({tag, "_wait"}, m, 1'b0, '0);
         chk_mst({tag, "_other"}, 1 - m, 1'b0, '0);
         tick;
      end
      s_ack[k]  = 1'b1;
      s_rdat[k] = rd;
      #1;
      chk_route({tag, "_ack"}, m);
      chk_mst({tag, "_ack"}, m, 1'b1, rd);
      chk_mst({tag, "_other"}, 1 - m, 1'b0, '0);
      chk_err({tag, "_ack"}, 1'b0);
      tick;
      s_ack[k] = 1'b0;
      m_stb[m] = 1'b0;
   endtask

   task automatic rel(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      #1;
      chk_mst("rel", m, 1'b0, '0);
      tick;
   endtask

   // Starts in IDLE. Requesters raise cyc together; the model picks the
   // winner, and a waiting loser is served two cycles after the release.
   task automatic round(input logic r0, input logic r1, input logic [31:0] a0,
                        input logic [31:0] a1, input string tag);
      logic [31:0] a [2];
      int          w;
      a[0] = a0;
      a[1] = a1;
      if (r0) req(0, a0);
      if (r1) req(1, a1);
      #1;
      chk_route({tag, "_idle"}, -1);
      tick;
      w = (r0 && r1) ? 1 - model_last : (r0 ? 0 : 1);
      model_last = w;
      xfer(w, a[w], $urandom_range(0, 3), $urandom, {tag, "_win"});
      rel(w);
      if ((w == 0) ? r1 : r0) begin
         #1;
         chk_route({tag, "_gap"}, -1);
         chk_mst({tag, "_gap"}, 1 - w, 1'b0, '0);
         tick;
         model_last = 1 - w;
         xfer(1 - w, a[1 - w], $urandom_range(0, 3), $urandom, {tag, "_lose"});
         rel(1 - w);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] rd;
      logic [1:0]  r;

      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         m_addr[m] = '0; m_wdat[m] = '0; m_we[m] = 1'b0;
         m_sel[m]  = '0; m_stb[m]  = 1'b0; m_cyc[m] = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
         s_rdat[j] = $urandom;
         s_ack[j]  = 1'b0;
      end
      model_last = 1;
      tick;
      tick;
      chk_route("rst", -1);
      chk_mst("rst", 0, 1'b0, '0);
      chk_mst("rst", 1, 1'b0, '0);
      chk_err("rst", 1'b0);
      rst = 1'b0;

      // First tie after reset goes to m0; m1 (ROM addr 4) follows.
      round(1'b1, 1'b1, rnd_addr(1), 32'h0000_0004, "tie");

      // m0 RAM read, ack one cycle after the strobe.
      req(0, 32'h1000_0010);
      #1;
      chk_route("ram_idle", -1);
      tick;
      model_last = 0;
      xfer(0, 32'h1000_0010, 1, 32'hCAFE_F00D, "ram_rd");
      rel(0);

      // m1 burst of ROM fetches while m0 waits for RAM.
      req(1, 32'h0000_0000);
      #1;
      chk_route("rom_idle", -1);
      tick;
      model_last = 1;
      a = rnd_addr(1);
      req(0, a);
      for (int i = 0; i < 4; i++) begin
         xfer(1, 32'(i * 4), $urandom_range(0, 2), $urandom, "rom_fetch");
      end
      rel(1);
      #1;
      chk_route("rom_gap", -1);
      tick;
      model_last = 0;
      xfer(0, a, 1, $urandom, "ram_after");
      rel(0);
      round(1'b1, 1'b1, rnd_addr(2), rnd_addr(0), "tie2");

      // Unmapped accesses: tag 7, then a random tag in 4..15.
      req(0, 32'h7000_0000);
      m_we[0] = 1'b1;
      #1;
      chk_route("unm_idle", -1);
      tick;
      model_last = 0;
      for (int n = 0; n < 2; n++) begin
         if (n == 1) begin
            a = {4'($urandom_range(4, 15)), 28'($urandom)};
            m_addr[0] = a;
            m_stb[0]  = 1'b1;
         end
         for (int j = 0; j < 4; j++) s_rdat[j] = $urandom;
         #1;
         chk_route("unm_gnt", 0);
         chk_mst("unm_gnt", 0, 1'b0, '0);
         chk_err("unm_gnt", 1'b0);
         tick;
         chk_route("unm_err", -1);
         chk_mst("unm_err", 0, 1'b1, '0);
         chk_mst("unm_err", 1, 1'b0, '0);
         chk_err("unm_err", 1'b1);
         m_stb[0] = 1'b0;
         tick;
         chk_mst("unm_after", 0, 1'b0, '0);
         chk_err("unm_after", 1'b0);
      end
      rel(0);

      // GPIO never acks: forced completion after 255 unacked strobe cycles.
      a = rnd_addr(2);
      req(0, a);
      #1;
      chk_route("to_idle", -1);
      tick;
      model_last = 0;
      for (int i = 0; i < 255; i++) begin
         s_rdat[2] = $urandom;
         #1;
         chk_route("to_wait", 0);
         chk_mst("to_wait", 0, 1'b0, '0);
         chk_err("to_wait", 1'b0);
         tick;
      end
      chk_route("to_fire", -1);
      chk_mst("to_fire", 0, 1'b1, '0);
      chk_err("to_fire", 1'b1);
      m_stb[0] = 1'b0;
      tick;
      chk_mst("to_after", 0, 1'b0, '0);
      chk_err("to_after", 1'b0);
      rel(0);

      // m1 to RAM next, with a stray GPIO ack that must be ignored.
      a = rnd_addr(1);
      req(1, a);
      s_ack[2] = 1'b1;
      #1;
      chk_route("stray_idle", -1);
      chk_mst("stray_idle", 1, 1'b0, '0);
      tick;
      model_last = 1;
      xfer(1, a, 2, $urandom, "after_to");
      s_ack[2] = 1'b0;
      rel(1);

      // Random request patterns and slaves.
      for (int n = 0; n < 24; n++) begin
         r = 2'($urandom_range(1, 3));
         round(r[0], r[1], rnd_addr($urandom_range(0, 3)), rnd_addr($urandom_range(0, 3)), "rnd");
      end

      // Asynchronous reset while m1 is mid-transfer to the UART.
      a = rnd_addr(3);
      req(1, a);
      #1;
      chk_route("rm_idle", -1);
      tick;
      model_last = 1;
      rd = $urandom;
      s_rdat[3] = rd;
      s_ack[3]  = 1'b1;
      #1;
      chk_route("rm_gnt", 1);
      chk_mst("rm_gnt", 1, 1'b1, rd);
      #1;
      rst = 1'b1;
      #1;
      chk_route("rm_rst", -1);
      chk_mst("rm_rst", 1, 1'b0, '0);
      chk_err("rm_rst", 1'b0);
      s_ack[3] = 1'b0;
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      model_last = 1;
      round(1'b1, 1'b1, rnd_addr(1), rnd_addr(3), "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
